// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer: Avalon-MM master that programs a button PIO's irq mask, then turns each irq into a valid/ready event word.
module pio_irq_servicer #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] IRQ_MASK = 4'hF,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic [15:0]      evt_count,
  output logic             busy
);
  typedef enum logic [2:0] {INIT, IDLE, RD_CAP, CLR, RD_DAT, EVT} state_t;
  state_t state, state_d;
  logic [1:0] cnt, cnt_d;
  logic [WIDTH-1:0] cap, cap_d, edges_d, level_d;
  logic valid_d, rd_done, wr_d;
  logic [15:0] count_d;
  if (WIDTH < 32) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^avm_readdata[31:WIDTH];
  end
  assign rd_done = cnt == 2'(READ_LATENCY - 1);
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    cap_d = cap;
    edges_d = evt_edges;
    level_d = evt_level;
    valid_d = evt_valid;
    count_d = evt_count;
    case (state)
      INIT: begin
        state_d = cnt != 2'd0 ? IDLE : INIT;
        cnt_d = cnt != 2'd0 ? 2'd0 : 2'd1;
      end
      IDLE: state_d = irq ? RD_CAP : IDLE;
      RD_CAP: begin
        cap_d = rd_done ? avm_readdata[WIDTH-1:0] & IRQ_MASK : cap;
        state_d = rd_done ? CLR : RD_CAP;
        cnt_d = rd_done ? 2'd0 : cnt + 2'd1;
      end
      CLR: state_d = cap == '0 ? IDLE : RD_DAT;
      RD_DAT: begin
        level_d = rd_done ? avm_readdata[WIDTH-1:0] : evt_level;
        edges_d = rd_done ? cap : evt_edges;
        valid_d = rd_done;
        state_d = rd_done ? EVT : RD_DAT;
        cnt_d = rd_done ? 2'd0 : cnt + 2'd1;
      end
      EVT: begin
        valid_d = !evt_ready;
        count_d = evt_ready ? evt_count + 16'd1 : evt_count;
        state_d = evt_ready ? IDLE : EVT;
      end
      default: begin
        state_d = INIT;
        cnt_d = 2'd0;
      end
    endcase
  end
  assign wr_d = state_d == INIT || state_d == CLR;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt <= '0;
      cap <= '0;
      avm_address <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n <= 1'b1;
      avm_writedata <= '0;
      evt_valid <= 1'b0;
      evt_edges <= '0;
      evt_level <= '0;
      evt_count <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      cap <= cap_d;
      avm_address <= state_d == INIT ? 2'd2 : (state_d == RD_CAP || state_d == CLR) ? 2'd3 : 2'd0;
      avm_chipselect <= wr_d || state_d == RD_CAP || state_d == RD_DAT;
      avm_write_n <= !wr_d;
      avm_writedata <= state_d == INIT ? 32'(IRQ_MASK) : 32'd0;
      evt_valid <= valid_d;
      evt_edges <= edges_d;
      evt_level <= level_d;
      evt_count <= count_d;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_pio_irq_servicer.sv
// tb_pio_irq_servicer: three servicers (default, IRQ_MASK=1, READ_LATENCY=3), each on its own PIO slave model.
module tb_pio_irq_servicer;
  localparam logic [3:0] MSK [3] = '{4'hF, 4'h1, 4'hF};
  localparam int RLS [3] = '{1, 1, 3};
  typedef struct {logic wn; logic [1:0] a; int len; logic [31:0] wd;} acc_t;
  typedef struct {logic [3:0] cap, lvl, edg, lv; logic [15:0] cnt;} vec_t;
  logic clk = 1'b0;
  logic rst_n [3];
  logic [1:0] addr [3];
  logic cs [3], wn [3], ev [3], rdy [3], bsy [3], frc [3];
  logic [31:0] wd [3];
  logic [3:0] eg [3], lv [3], setc [3], lvin [3];
  logic [15:0] cnt [3];
  acc_t lg [3][64];
  int ln [3] = '{0, 0, 0};
  logic pcs [3] = '{1'b0, 1'b0, 1'b0};
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gi
    logic [3:0] ecap = '0, smask = '0;
    logic [31:0] dec, d1 = '0, d2 = '0, rd;
    logic irq_s;
    pio_irq_servicer #(.WIDTH(4), .IRQ_MASK(MSK[g]), .READ_LATENCY(RLS[g])) u (
      .clk(clk), .reset_n(rst_n[g]), .avm_address(addr[g]), .avm_chipselect(cs[g]),
      .avm_write_n(wn[g]), .avm_writedata(wd[g]), .avm_readdata(rd), .irq(irq_s),
      .evt_valid(ev[g]), .evt_ready(rdy[g]), .evt_edges(eg[g]), .evt_level(lv[g]),
      .evt_count(cnt[g]), .busy(bsy[g]));
    assign dec = (cs[g] && wn[g]) ? (addr[g] == 2'd0 ? {28'd0, lvin[g]} : addr[g] == 2'd2 ? {28'd0, smask} :
                 addr[g] == 2'd3 ? {28'd0, ecap} : 32'd0) : 32'hDEAD0000;
    assign rd = RLS[g] == 1 ? dec : RLS[g] == 2 ? d1 : d2;
    assign irq_s = |(ecap & smask) | frc[g];
    always @(posedge clk) begin
      d1 <= dec;
      d2 <= d1;
      if (cs[g] && !wn[g] && addr[g] == 2'd2) smask <= wd[g][3:0];
      ecap <= (cs[g] && !wn[g] && addr[g] == 2'd3) ? 4'd0 : ecap | setc[g];
    end
  end
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (cs[i]) begin
        if (pcs[i] && ln[i] > 0 && lg[i][ln[i]-1].wn == wn[i] && lg[i][ln[i]-1].a == addr[i])
          lg[i][ln[i]-1].len <= lg[i][ln[i]-1].len + 1;
        else if (ln[i] < 64) begin
          lg[i][ln[i]] <= '{wn[i], addr[i], 1, wd[i]};
          ln[i] <= ln[i] + 1;
        end
      end
      pcs[i] <= cs[i];
    end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_acc(input string nm, input int i, input int k, input logic w, input logic [1:0] a, input int len, input logic [31:0] d);
    chk(nm, {lg[i][k].wn, lg[i][k].a, 8'(lg[i][k].len), lg[i][k].wd}, {w, a, 8'(len), d});
  endtask
  task automatic wait_valid(input int i, output int n);
    n = 0;
    while (!ev[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_idle(input int i);
    for (int n = 0; n < 40 && bsy[i]; n++) @(negedge clk);
  endtask
  initial begin
    vec_t tv [4];
    int n, b, c0;
    logic [3:0] e0, l0;
    logic stable, nobus, sawv, inj;
    tv[0] = '{4'b0010, 4'b1101, 4'b0010, 4'b1101, 16'd1};
    tv[1] = '{4'b0101, 4'b0000, 4'b0101, 4'b0000, 16'd2};
    tv[2] = '{4'b1111, 4'b1010, 4'b1111, 4'b1010, 16'd3};
    tv[3] = '{4'b1000, 4'b0111, 4'b1000, 4'b0111, 16'd4};
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; setc[i] = '0; lvin[i] = '0; frc[i] = 1'b0; rdy[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("reset_state", {cs[0], wn[0], addr[0], wd[0], ev[0], eg[0], lv[0], cnt[0], bsy[0]},
        {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 4'd0, 4'd0, 16'd0, 1'b0});
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    repeat (4) @(negedge clk);
    chk_acc("init_wr0", 0, 0, 1'b0, 2'd2, 1, 32'h0000000F);
    chk_acc("init_wr1", 1, 0, 1'b0, 2'd2, 1, 32'h00000001);
    chk("init_n_acc", 64'(ln[0]), 64'd1);
    chk("init_busy", {bsy[0], bsy[1], bsy[2]}, 3'b000);
    for (int v = 0; v < 4; v++) begin
      b = ln[0];
      lvin[0] = tv[v].lvl;
      setc[0] = tv[v].cap;
      @(negedge clk);
      setc[0] = '0;
      wait_valid(0, n);
      chk($sformatf("lat[%0d]", v), 64'(n), 64'd4);
      chk($sformatf("edges[%0d]", v), eg[0], tv[v].edg);
      chk($sformatf("level[%0d]", v), lv[0], tv[v].lv);
      @(negedge clk);
      chk($sformatf("vwidth[%0d]", v), ev[0], 1'b0);
      chk($sformatf("count[%0d]", v), cnt[0], tv[v].cnt);
      wait_idle(0);
      chk($sformatf("n_acc[%0d]", v), 64'(ln[0] - b), 64'd3);
      chk_acc($sformatf("rd_cap[%0d]", v), 0, b, 1'b1, 2'd3, 1, 32'd0);
      chk_acc($sformatf("clr[%0d]", v), 0, b + 1, 1'b0, 2'd3, 1, 32'd0);
      chk_acc($sformatf("rd_dat[%0d]", v), 0, b + 2, 1'b1, 2'd0, 1, 32'd0);
    end
    rdy[0] = 1'b0;
    lvin[0] = 4'b0011;
    setc[0] = 4'b0001;
    @(negedge clk);
    setc[0] = '0;
    wait_valid(0, n);
    chk("bp_edges", eg[0], 4'b0001);
    chk("bp_level", lv[0], 4'b0011);
    e0 = eg[0]; l0 = lv[0]; c0 = int'(cnt[0]);
    lvin[0] = 4'b0110;
    setc[0] = 4'b1000;
    stable = 1'b1; nobus = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      setc[0] = '0;
      if (!ev[0] || eg[0] != e0 || lv[0] != l0 || int'(cnt[0]) != c0) stable = 1'b0;
      if (cs[0]) nobus = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    chk("bp_nobus", nobus, 1'b1);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release", {ev[0], cnt[0]}, {1'b0, 16'(c0 + 1)});
    wait_valid(0, n);
    chk("pend_edges", eg[0], 4'b1000);
    chk("pend_level", lv[0], 4'b0110);
    @(negedge clk);
    chk("pend_count", cnt[0], 16'(c0 + 2));
    wait_idle(0);
    b = ln[1];
    setc[1] = 4'b0100;
    @(negedge clk);
    setc[1] = '0;
    frc[1] = 1'b1;
    @(negedge clk);
    frc[1] = 1'b0;
    sawv = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ev[1]) sawv = 1'b1;
    end
    chk("spur_novalid", sawv, 1'b0);
    chk("spur_idle", {bsy[1], cnt[1]}, {1'b0, 16'd0});
    chk("spur_cleared", gi[1].ecap, 4'd0);
    chk("spur_n_acc", 64'(ln[1] - b), 64'd2);
    chk_acc("spur_rd", 1, b, 1'b1, 2'd3, 1, 32'd0);
    chk_acc("spur_clr", 1, b + 1, 1'b0, 2'd3, 1, 32'd0);
    b = ln[2];
    lvin[2] = 4'b0110;
    setc[2] = 4'b0100;
    @(negedge clk);
    setc[2] = '0;
    n = 0; inj = 1'b0;
    while (!ev[2] && n < 40) begin
      @(negedge clk);
      n++;
      setc[2] = (cs[2] && wn[2] && addr[2] == 2'd0 && !inj) ? 4'b1001 : 4'b0000;
      if (setc[2] != 0) inj = 1'b1;
    end
    setc[2] = '0;
    chk("rl3_lat", 64'(n), 64'd8);
    chk("rl3_edges1", eg[2], 4'b0100);
    chk("rl3_level1", lv[2], 4'b0110);
    @(negedge clk);
    wait_valid(2, n);
    chk("rl3_edges2", eg[2], 4'b1001);
    chk("rl3_level2", lv[2], 4'b0110);
    @(negedge clk);
    chk("rl3_count", cnt[2], 16'd2);
    wait_idle(2);
    chk("rl3_n_acc", 64'(ln[2] - b), 64'd6);
    for (int k = 0; k < 6; k++)
      chk_acc($sformatf("rl3_acc[%0d]", k), 2, b + k, k % 3 != 1, k % 3 == 2 ? 2'd0 : 2'd3, k % 3 == 1 ? 1 : 3, 32'd0);
    setc[0] = 4'b0010;
    @(negedge clk);
    setc[0] = '0;
    n = 0;
    while (!(cs[0] && wn[0] && addr[0] == 2'd0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_rd_dat", n < 40, 1'b1);
    rst_n[0] = 1'b0;
    #1;
    chk("rst_async", {ev[0], cnt[0], wn[0], cs[0], bsy[0]}, {1'b0, 16'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    b = ln[0];
    rst_n[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_n_acc", 64'(ln[0] - b), 64'd1);
    chk_acc("rst_init_wr", 0, b, 1'b0, 2'd2, 1, 32'h0000000F);
    chk("rst_after", {ev[0], bsy[0], cnt[0]}, {1'b0, 1'b0, 16'd0});
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
